// File: rtl/axi4_mem_arbiter.sv
// Two-port memory arbiter that serialises requester transactions onto one AXI4-lite master.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise p0 has fixed priority.
module axi4_mem_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_valid,
    input  logic        p0_instr,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wstrb,
    output logic        p0_ready,
    output logic [31:0] p0_rdata,

    input  logic        p1_valid,
    input  logic        p1_instr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wstrb,
    output logic        p1_ready,
    output logic [31:0] p1_rdata,

    output logic        grant,

    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RADDR = 3'd1;
    localparam logic [2:0] RDATA = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] WRESP = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        grant_q, grant_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        instr_q, instr_d;
    logic [31:0] data_q, data_d;
    logic        arvalid_q, arvalid_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        rready_q, rready_d;
    logic        bready_q, bready_d;
    logic        p0_ready_q, p0_ready_d;
    logic        p1_ready_q, p1_ready_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;

    logic        any_valid;
    logic        win;
    logic        win_instr;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_wstrb;

    always_comb begin
        any_valid = p0_valid | p1_valid;
`ifdef ARB_ROUND_ROBIN_EN
        if (p0_valid && p1_valid) begin
            win = rr_ptr_q;
        end else begin
            win = p1_valid;
        end
`else
        win = ~p0_valid;
`endif
        win_instr = win ? p1_instr : p0_instr;
        win_addr  = win ? p1_addr  : p0_addr;
        win_wdata = win ? p1_wdata : p0_wdata;
        win_wstrb = win ? p1_wstrb : p0_wstrb;
    end

    // NOTE: every _d starts as its _q so no path through the case leaves a variable unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        instr_d    = instr_q;
        data_d     = data_q;
        arvalid_d  = arvalid_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        rready_d   = rready_q;
        bready_d   = bready_q;
        p0_ready_d = 1'b0;
        p1_ready_d = 1'b0;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;

        case (state_q)
            IDLE: begin
                // While a ready pulse is out, the requester has not yet seen it and still holds valid.
                if (any_valid && !p0_ready_q && !p1_ready_q) begin
                    grant_d = win;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    wstrb_d = win_wstrb;
                    instr_d = win_instr;
                    data_d  = 32'h0;
                    if (win_addr >= ADDR_LIMIT) begin
                        state_d = DONE;
                    end else if (win_wstrb == 4'b0000) begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            RADDR: begin
                if (mem_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (mem_axi_rvalid) begin
                    data_d   = mem_axi_rdata;
                    rready_d = 1'b0;
                    state_d  = DONE;
                end
            end
            WRITE: begin
                if (mem_axi_awready) awvalid_d = 1'b0;
                if (mem_axi_wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || mem_axi_awready) && (!wvalid_q || mem_axi_wready)) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (mem_axi_bvalid) begin
                    bready_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (grant_q) begin
                    p1_ready_d = 1'b1;
                    p1_rdata_d = data_q;
                end else begin
                    p0_ready_d = 1'b1;
                    p0_rdata_d = data_q;
                end
                rr_ptr_d = ~grant_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            instr_q    <= 1'b0;
            data_q     <= 32'h0;
            arvalid_q  <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            rready_q   <= 1'b0;
            bready_q   <= 1'b0;
            p0_ready_q <= 1'b0;
            p1_ready_q <= 1'b0;
            p0_rdata_q <= 32'h0;
            p1_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            instr_q    <= instr_d;
            data_q     <= data_d;
            arvalid_q  <= arvalid_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            rready_q   <= rready_d;
            bready_q   <= bready_d;
            p0_ready_q <= p0_ready_d;
            p1_ready_q <= p1_ready_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    assign grant           = grant_q;
    assign p0_ready        = p0_ready_q;
    assign p1_ready        = p1_ready_q;
    assign p0_rdata        = p0_rdata_q;
    assign p1_rdata        = p1_rdata_q;
    assign mem_axi_arvalid = arvalid_q;
    assign mem_axi_araddr  = addr_q;
    assign mem_axi_arprot  = {instr_q, 2'b00};
    assign mem_axi_rready  = rready_q;
    assign mem_axi_awvalid = awvalid_q;
    assign mem_axi_awaddr  = addr_q;
    assign mem_axi_awprot  = 3'b000;
    assign mem_axi_wvalid  = wvalid_q;
    assign mem_axi_wdata   = wdata_q;
    assign mem_axi_wstrb   = wstrb_q;
    assign mem_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Directed self-checking bench for axi4_mem_arbiter with a small AXI4-lite memory model.
module tb_axi4_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        p0_valid, p0_instr, p0_ready;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [3:0]  p0_wstrb;
    logic        p1_valid, p1_instr, p1_ready;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [3:0]  p1_wstrb;
    logic        grant;
    logic        mem_axi_awvalid, mem_axi_awready;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;
    logic        mem_axi_wvalid, mem_axi_wready;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid, mem_axi_bready;
    logic        mem_axi_arvalid, mem_axi_arready;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;
    logic        mem_axi_rvalid, mem_axi_rready;
    logic [31:0] mem_axi_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    axi4_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_instr(p0_instr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wstrb(p0_wstrb), .p0_ready(p0_ready), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_instr(p1_instr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wstrb(p1_wstrb), .p1_ready(p1_ready), .p1_rdata(p1_rdata),
        .grant(grant),
        .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
        .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
        .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
        .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
        .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
        .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
        .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
        .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
        .mem_axi_rdata(mem_axi_rdata)
    );

    // Memory model: word array indexed by addr[9:2], programmable AW and R delays.
    logic [31:0] mem [0:255];
    int          aw_delay = 0;
    int          r_delay  = 0;
    int          aw_cnt, r_cnt;
    logic        r_pend, aw_got, w_got;
    logic [31:0] r_word, aw_a, w_d;
    logic [3:0]  w_s;
    logic        have_aw, have_w;
    logic [31:0] wr_addr, wr_data, wr_word;
    logic [3:0]  wr_strb;

    assign mem_axi_arready = 1'b1;
    assign mem_axi_wready  = 1'b1;
    assign mem_axi_awready = mem_axi_awvalid && (aw_cnt >= aw_delay);

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= {16'hC0DE, 8'h00, 8'(i)};
            mem[64]        <= 32'hDEAD_BEEF;
            mem[128]       <= 32'hAABB_CCDD;
            mem_axi_rvalid <= 1'b0;
            mem_axi_rdata  <= 32'h0;
            mem_axi_bvalid <= 1'b0;
            r_pend <= 1'b0; r_cnt <= 0; aw_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            if (mem_axi_rvalid && mem_axi_rready) mem_axi_rvalid <= 1'b0;
            if (mem_axi_arvalid && mem_axi_arready) begin
                if (r_delay == 0) begin
                    mem_axi_rvalid <= 1'b1;
                    mem_axi_rdata  <= mem[mem_axi_araddr[9:2]];
                end else begin
                    r_word <= mem[mem_axi_araddr[9:2]];
                    r_pend <= 1'b1;
                    r_cnt  <= 1;
                end
            end else if (r_pend) begin
                if (r_cnt >= r_delay) begin
                    mem_axi_rvalid <= 1'b1;
                    mem_axi_rdata  <= r_word;
                    r_pend <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end

            if (mem_axi_bvalid && mem_axi_bready) mem_axi_bvalid <= 1'b0;
            if (mem_axi_awvalid && !mem_axi_awready) aw_cnt <= aw_cnt + 1;
            else if (mem_axi_awvalid && mem_axi_awready) aw_cnt <= 0;
            have_aw = aw_got || (mem_axi_awvalid && mem_axi_awready);
            have_w  = w_got  || (mem_axi_wvalid && mem_axi_wready);
            wr_addr = aw_got ? aw_a : mem_axi_awaddr;
            wr_data = w_got ? w_d : mem_axi_wdata;
            wr_strb = w_got ? w_s : mem_axi_wstrb;
            if (have_aw && have_w) begin
                wr_word = mem[wr_addr[9:2]];
                for (int b = 0; b < 4; b++) if (wr_strb[b]) wr_word[8*b +: 8] = wr_data[8*b +: 8];
                mem[wr_addr[9:2]] <= wr_word;
                mem_axi_bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (mem_axi_awvalid && mem_axi_awready) begin aw_got <= 1'b1; aw_a <= mem_axi_awaddr; end
                if (mem_axi_wvalid && mem_axi_wready) begin
                    w_got <= 1'b1; w_d <= mem_axi_wdata; w_s <= mem_axi_wstrb;
                end
            end
        end
    end

    // Bus monitor: handshake bookkeeping and stability of stalled channels.
    logic        ar_st = 1'b0, aw_st = 1'b0, w_st = 1'b0;
    logic [31:0] ar_s, aw_s, wd_s;
    logic [3:0]  ws_s;
    int          ar_hs_cnt = 0, arvalid_cycles = 0, nr0 = 0, nr1 = 0;
    logic [31:0] last_araddr = 32'h0;
    logic [2:0]  last_arprot = 3'h0;

    always @(posedge clk) begin
        ar_st <= !reset && mem_axi_arvalid && !mem_axi_arready;
        aw_st <= !reset && mem_axi_awvalid && !mem_axi_awready;
        w_st  <= !reset && mem_axi_wvalid && !mem_axi_wready;
        ar_s <= mem_axi_araddr; aw_s <= mem_axi_awaddr; wd_s <= mem_axi_wdata; ws_s <= mem_axi_wstrb;
        if (!reset && mem_axi_arvalid) arvalid_cycles <= arvalid_cycles + 1;
        if (!reset && mem_axi_arvalid && mem_axi_arready) begin
            ar_hs_cnt   <= ar_hs_cnt + 1;
            last_araddr <= mem_axi_araddr;
            last_arprot <= mem_axi_arprot;
        end
    end

    always @(negedge clk) begin
        if (ar_st) begin
            n_checks++;
            if (mem_axi_arvalid !== 1'b1 || mem_axi_araddr !== ar_s) begin
                $display("FAIL ar_stable: arvalid=%b araddr=%h, required 1/%h", mem_axi_arvalid, mem_axi_araddr, ar_s);
                n_fail++;
            end
        end
        if (aw_st) begin
            n_checks++;
            if (mem_axi_awvalid !== 1'b1 || mem_axi_awaddr !== aw_s) begin
                $display("FAIL aw_stable: awvalid=%b awaddr=%h, required 1/%h", mem_axi_awvalid, mem_axi_awaddr, aw_s);
                n_fail++;
            end
        end
        if (w_st) begin
            n_checks++;
            if (mem_axi_wvalid !== 1'b1 || mem_axi_wdata !== wd_s || mem_axi_wstrb !== ws_s) begin
                $display("FAIL w_stable: wvalid=%b wdata=%h, required 1/%h", mem_axi_wvalid, mem_axi_wdata, wd_s);
                n_fail++;
            end
        end
        if (p0_ready === 1'b1 || p1_ready === 1'b1) begin
            n_checks++;
            if (p0_ready === 1'b1 && p1_ready === 1'b1) begin
                $display("FAIL ready_exclusive: p0_ready=1 p1_ready=1, required at most one");
                n_fail++;
            end
        end
        if (p0_ready === 1'b1) nr0++;
        if (p1_ready === 1'b1) nr1++;
    end

    // Drives one request, waits (bounded) for its ready pulse, then samples ready one cycle later.
    task automatic req(input bit port, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb, input bit hold,
                       output bit seen, output int lat, output logic [31:0] rd, output logic ready_after);
        seen = 1'b0; lat = 0; rd = 32'h0; ready_after = 1'b0;
        @(negedge clk);
        if (port) begin
            p1_valid = 1'b1; p1_instr = instr; p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb;
        end else begin
            p0_valid = 1'b1; p0_instr = instr; p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb;
        end
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (port ? p1_ready : p0_ready) begin
                seen = 1'b1; lat = k; rd = port ? p1_rdata : p0_rdata;
            end
            if (seen || !hold) begin
                if (port) p1_valid = 1'b0; else p0_valid = 1'b0;
            end
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        @(negedge clk);
        ready_after = port ? p1_ready : p0_ready;
    endtask

    bit          seen;
    int          lat;
    logic [31:0] rd;
    logic        rdy_after;

    task automatic test_reset();
        reset = 1'b1;
        p0_valid = 0; p0_instr = 0; p0_addr = 0; p0_wdata = 0; p0_wstrb = 0;
        p1_valid = 0; p1_instr = 0; p1_addr = 0; p1_wdata = 0; p1_wstrb = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_axi_arvalid, mem_axi_awvalid, mem_axi_wvalid, mem_axi_rready, mem_axi_bready,
             p0_ready, p1_ready} !== 7'b0) begin
            $display("FAIL reset_valids: %b, required 0000000", {mem_axi_arvalid, mem_axi_awvalid,
                     mem_axi_wvalid, mem_axi_rready, mem_axi_bready, p0_ready, p1_ready});
            n_fail++;
        end
        n_checks++;
        if (grant !== 1'b0 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            $display("FAIL reset_data: grant=%b p0_rdata=%h p1_rdata=%h, required 0/0/0", grant, p0_rdata, p1_rdata);
            n_fail++;
        end
        reset = 1'b0;
    endtask

    task automatic test_read();
        int hs0, n1;
        hs0 = ar_hs_cnt; n1 = nr1;
        req(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 1'b1, seen, lat, rd, rdy_after);
        n_checks++;
        if (!seen || lat != 4) begin
            $display("FAIL read_latency: seen=%0d latency=%0d, required 1/4", seen, lat); n_fail++;
        end
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            $display("FAIL read_rdata: %h, required deadbeef", rd); n_fail++;
        end
        n_checks++;
        if (last_araddr !== 32'h100 || last_arprot !== 3'b100 || ar_hs_cnt != hs0 + 1) begin
            $display("FAIL read_ar: araddr=%h arprot=%b handshakes=%0d, required 100/100/%0d",
                     last_araddr, last_arprot, ar_hs_cnt - hs0, 1);
            n_fail++;
        end
        n_checks++;
        if (rdy_after !== 1'b0 || nr1 != n1) begin
            $display("FAIL read_pulse: ready_after=%b p1_pulses=%0d, required 0/0", rdy_after, nr1 - n1); n_fail++;
        end
    endtask

    task automatic test_write();
        int n0;
        n0 = nr0;
        aw_delay = 3;
        @(negedge clk);
        p1_valid = 1'b1; p1_instr = 1'b0; p1_addr = 32'h200; p1_wdata = 32'h1122_3344; p1_wstrb = 4'b0011;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if ({mem_axi_awvalid, mem_axi_wvalid} !== 2'b11 || mem_axi_awprot !== 3'b000) begin
                    $display("FAIL write_k1: aw/w=%b awprot=%b, required 11/000", {mem_axi_awvalid, mem_axi_wvalid}, mem_axi_awprot);
                    n_fail++;
                end
            end
            if (k >= 2 && k <= 4) begin
                n_checks++;
                if ({mem_axi_awvalid, mem_axi_wvalid, grant} !== 3'b101) begin
                    $display("FAIL write_wfirst: cycle %0d aw/w/grant=%b, required 101", k,
                             {mem_axi_awvalid, mem_axi_wvalid, grant});
                    n_fail++;
                end
            end
            if (k == 5) begin
                n_checks++;
                if ({mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready} !== 3'b001) begin
                    $display("FAIL write_wresp: aw/w/bready=%b, required 001", {mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready});
                    n_fail++;
                end
            end
            if (k == 6) begin
                n_checks++;
                if (p1_ready !== 1'b0) begin
                    $display("FAIL write_early_ready: p1_ready=%b, required 0", p1_ready); n_fail++;
                end
            end
            if (k == 7) begin
                n_checks++;
                if (p1_ready !== 1'b1 || p1_rdata !== 32'h0) begin
                    $display("FAIL write_ready: p1_ready=%b p1_rdata=%h, required 1/0", p1_ready, p1_rdata); n_fail++;
                end
                p1_valid = 1'b0;
            end
            if (k == 8) begin
                n_checks++;
                if (p1_ready !== 1'b0 || nr0 != n0) begin
                    $display("FAIL write_pulse: p1_ready=%b p0_pulses=%0d, required 0/0", p1_ready, nr0 - n0); n_fail++;
                end
            end
        end
        n_checks++;
        if (mem[128] !== 32'hAABB_3344) begin
            $display("FAIL write_mem: %h, required aabb3344", mem[128]); n_fail++;
        end
        aw_delay = 0;
    endtask

    task automatic test_bypass();
        int arc;
        arc = arvalid_cycles;
        req(1'b0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b1, seen, lat, rd, rdy_after);
        n_checks++;
        if (!seen || lat != 2 || rd !== 32'h0 || arvalid_cycles != arc) begin
            $display("FAIL bypass: seen=%0d latency=%0d rdata=%h arvalid_cycles=%0d, required 1/2/0/0",
                     seen, lat, rd, arvalid_cycles - arc);
            n_fail++;
        end
        req(1'b0, 1'b0, 32'h0000_FFFC, 32'h0, 4'h0, 1'b1, seen, lat, rd, rdy_after);
        n_checks++;
        if (!seen || lat != 4 || rd !== 32'hC0DE_00FF || last_araddr !== 32'h0000_FFFC) begin
            $display("FAIL below_limit: seen=%0d latency=%0d rdata=%h araddr=%h, required 1/4/c0de00ff/0000fffc",
                     seen, lat, rd, last_araddr);
            n_fail++;
        end
    endtask

    task automatic test_valid_drop();
        req(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b0, seen, lat, rd, rdy_after);
        n_checks++;
        if (!seen || lat != 4 || rd !== 32'hC0DE_0041 || rdy_after !== 1'b0) begin
            $display("FAIL valid_drop: seen=%0d latency=%0d rdata=%h ready_after=%b, required 1/4/c0de0041/0",
                     seen, lat, rd, rdy_after);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int order[8];
        int exp_order[8];
        int n, n0, n1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        n = 0; n0 = 0; n1 = 0;
        for (int i = 0; i < 8; i++) order[i] = -1;
        @(negedge clk);
        p0_addr = 32'h10; p0_wstrb = 4'h0; p0_instr = 1'b0; p0_valid = 1'b1;
        p1_addr = 32'h14; p1_wstrb = 4'h0; p1_instr = 1'b0; p1_valid = 1'b1;
        for (int k = 0; k < 300 && n < 8; k++) begin
            @(negedge clk);
            if (p0_ready === 1'b1) begin
                if (n < 8) order[n] = 0;
                n++; n0++;
                n_checks++;
                if (p0_rdata !== 32'hC0DE_0004) begin
                    $display("FAIL b2b_p0_rdata: %h, required c0de0004", p0_rdata); n_fail++;
                end
                if (n0 == 4) p0_valid = 1'b0;
            end
            if (p1_ready === 1'b1) begin
                if (n < 8) order[n] = 1;
                n++; n1++;
                n_checks++;
                if (p1_rdata !== 32'hC0DE_0005) begin
                    $display("FAIL b2b_p1_rdata: %h, required c0de0005", p1_rdata); n_fail++;
                end
                if (n1 == 4) p1_valid = 1'b0;
            end
        end
        p0_valid = 1'b0; p1_valid = 1'b0;
        n_checks++;
        if (n != 8) begin
            $display("FAIL b2b_count: %0d completions, required 8", n); n_fail++;
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (order[i] != exp_order[i]) begin
                $display("FAIL b2b_order[%0d]: grant %0d, required %0d", i, order[i], exp_order[i]); n_fail++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit found;
        int n1;
        found = 1'b0;
        r_delay = 5;
        @(negedge clk);
        p1_valid = 1'b1; p1_instr = 1'b0; p1_addr = 32'h100; p1_wstrb = 4'h0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (mem_axi_rready === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found || grant !== 1'b1) begin
            $display("FAIL mid_rdata_reached: found=%0d grant=%b, required 1/1", found, grant); n_fail++;
        end
        reset = 1'b1; p1_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_axi_arvalid, mem_axi_awvalid, mem_axi_wvalid, mem_axi_rready, mem_axi_bready,
             p0_ready, p1_ready, grant} !== 8'b0 || p1_rdata !== 32'h0) begin
            $display("FAIL mid_reset: flags=%b p1_rdata=%h, required 00000000/0", {mem_axi_arvalid, mem_axi_awvalid,
                     mem_axi_wvalid, mem_axi_rready, mem_axi_bready, p0_ready, p1_ready, grant}, p1_rdata);
            n_fail++;
        end
        reset = 1'b0;
        r_delay = 0;
        n1 = nr1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (nr1 != n1) begin
            $display("FAIL mid_no_pulse: %0d pulses, required 0", nr1 - n1); n_fail++;
        end
        req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b1, seen, lat, rd, rdy_after);
        n_checks++;
        if (!seen || lat != 4 || rd !== 32'hDEAD_BEEF) begin
            $display("FAIL post_reset_read: seen=%0d latency=%0d rdata=%h, required 1/4/deadbeef", seen, lat, rd);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_bypass();
        test_valid_drop();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_mem_arbiter.md
AXI4_MEM_ARBITER -- requirements
Module: axi4_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 32'h0001_0000, the byte-address bound; requests at or above it are not forwarded.
REQ-002 SHALL have port clk, input, 1, the sole clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports pN_valid, input, 1, request from requester N (N=0,1).
REQ-005 SHALL have ports pN_instr, input, 1, instruction fetch flag.
REQ-006 SHALL have ports pN_addr, input, 32, byte address.
REQ-007 SHALL have ports pN_wdata, input, 32, write data.
REQ-008 SHALL have ports pN_wstrb, input, 4, byte strobes; 0 means read.
REQ-009 SHALL have ports pN_ready, output, 1, one-cycle completion pulse.
REQ-010 SHALL have ports pN_rdata, output, 32, read data, valid while pN_ready=1.
REQ-011 SHALL have port grant, output, 1, index of the requester owning the transaction in flight.
REQ-012 SHALL have AXI4-lite master ports: mem_axi_awvalid/awready/awaddr[31:0]/awprot[2:0], wvalid/wready/wdata[31:0]/wstrb[3:0], bvalid/bready, arvalid/arready/araddr[31:0]/arprot[2:0], rvalid/rready/rdata[31:0], with standard directions.

Function
REQ-013 SHALL use FSM states IDLE, RADDR, RDATA, WRITE, WRESP, DONE.
REQ-014 IDLE: when any pN_valid=1, the FSM SHALL select a winner per REQ-024, latch its addr/wdata/wstrb/instr, set grant, and go to RADDR if wstrb==0, else WRITE.
REQ-015 RADDR SHALL assert arvalid with araddr = latched addr and arprot = {instr,2'b00}; on arvalid&&arready, it SHALL drop arvalid and go to RDATA.
REQ-016 RDATA SHALL hold rready=1; on rvalid, it SHALL capture rdata and go to DONE.
REQ-017 WRITE SHALL assert awvalid and wvalid together with awprot=3'b000; each valid SHALL drop independently on its own handshake; when both have handshaked (same or different cycles), the FSM SHALL go to WRESP.
REQ-018 WRESP SHALL hold bready=1; on bvalid, it SHALL go to DONE.
REQ-019 DONE SHALL pulse p[grant]_ready for exactly one cycle, drive p[grant]_rdata with the captured data (0 for writes), and return to IDLE; the other pN_ready SHALL stay 0.
REQ-020 Requests with addr >= ADDR_LIMIT SHALL bypass AXI: IDLE->DONE, rdata = 32'h0, no AXI valid asserted.
REQ-021 Minimum latency SHALL be 4 cycles from pN_valid sampled in IDLE to pN_ready with zero-wait memory; the FSM SHALL return to IDLE for one cycle before starting the next grant.
REQ-022 AXI valids SHALL NOT drop before their handshake; araddr/awaddr/wdata/wstrb SHALL stay stable while their valid is high.
REQ-023 A requester deasserting pN_valid mid-transaction SHALL NOT abort it; the transaction SHALL complete on AXI and the ready pulse SHALL still be issued.
REQ-024 Arbitration: when both pN_valid are asserted in IDLE, the winner SHALL be chosen per REQ-028/REQ-029; a lone request SHALL always win.

Reset
REQ-025 reset=1 SHALL force state IDLE, grant=0, round-robin pointer=0, and all valid/ready outputs (awvalid, wvalid, arvalid, rready, bready, p0_ready, p1_ready) to 0.
REQ-026 rdata outputs SHALL reset to 0; reset mid-transaction SHALL abandon it without a ready pulse.
REQ-027 The first cycle after reset deasserts SHALL be IDLE.

Configuration
REQ-028 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the requester not granted last (pointer toggles at each DONE), with pointer=0 after reset favouring p0.
REQ-029 Without ARB_ROUND_ROBIN_EN, p0 SHALL always win simultaneous requests (fixed priority).

Verification
REQ-030 p0 read addr 0x100, instr=1, memory word 0xDEADBEEF, arready/rvalid immediate -> araddr=0x100, arprot=3'b100, p0_ready pulse with rdata=0xDEADBEEF 4 cycles later.
REQ-031 p1 write addr 0x200, wdata 0x11223344, wstrb 4'b0011; awready delayed 3 cycles, wready immediate -> wvalid drops first, awvalid holds until its handshake, p1_ready once after bvalid, memory 0x200 low half = 0x3344.
REQ-032 p0 and p1 both hold valid for 4 back-to-back reads -> with ARB_ROUND_ROBIN_EN grants alternate 0,1,0,1; without it, p0 completes all 4 before p1 is granted.
REQ-033 p0 read addr 0x0001_0000 -> no arvalid, p0_ready with rdata=0 two cycles later.
REQ-034 reset asserted in RDATA while rvalid pending -> next cycle all valids/readies 0 and state IDLE; a subsequent read completes normally.
